// File: rtl/man_jump_physics_pkg.sv
// Shared definitions for the jumping-man physics: state encoding and the
// physics scale constants the renderer also uses.
package man_jump_physics_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AIR  = 2'd1,
    ST_LAND = 2'd2
  } jump_state_e;

  localparam int DEF_GRAVITY = 4;
  localparam int DEF_HSPEED  = 2;

endpackage

// File: rtl/man_jump_integrator.sv
// Combinational one-tick step of the vertical motion: next height, next
// velocity and the landing condition for the current height/velocity.
module man_jump_integrator
  import man_jump_physics_pkg::*;
#(
  parameter int Y_W     = 16,
  parameter int V_W     = 10,
  parameter int GRAVITY = DEF_GRAVITY
) (
  input  logic        [Y_W-1:0] y,
  input  logic signed [V_W-1:0] v,
  output logic        [Y_W-1:0] y_next,
  output logic signed [V_W-1:0] v_next,
  output logic                  land
);

  localparam logic signed [V_W-1:0] G_S = V_W'(GRAVITY);

  logic signed [Y_W:0] s;
  logic                s_nonpos;
  logic                v_nonpos;

  // One extra bit so a descending step below ground shows up as negative.
  assign s        = $signed({1'b0, y}) + $signed({{(Y_W + 1 - V_W){v[V_W-1]}}, v});
  assign s_nonpos = s[Y_W] || (s == '0);
  assign v_nonpos = v[V_W-1] || (v == '0);
  assign land     = s_nonpos && v_nonpos;
  assign y_next   = s[Y_W-1:0];
  assign v_next   = v - G_S;

endmodule

// File: rtl/man_jump_physics.sv
// Jump motion integrator: latches launch velocity, steps height/velocity/
// distance on frame ticks, and pulses jump-done on landing.
module man_jump_physics
  import man_jump_physics_pkg::*;
#(
  parameter int V_INIT_W = 8,
  parameter int V_W      = 10,
  parameter int Y_W      = 16,
  parameter int X_W      = 12,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int HSPEED   = DEF_HSPEED
) (
  input  logic                  clk_machine,
  input  logic                  rst_machine,
  input  logic                  i_tick,
  input  logic                  i_jump_start,
  input  logic [V_INIT_W-1:0]   i_jump_v_init,
  output logic [Y_W-1:0]        o_man_y,
  output logic [X_W-1:0]        o_man_dx,
  output logic signed [V_W-1:0] o_vel,
  output logic                  o_busy,
  output logic                  o_falling,
  output logic                  o_jump_done
);

  // Strobe semantics: i_jump_start and i_tick are single-cycle pulses with no
  // back-pressure; start is taken only in IDLE, ticks only in AIR, all else dropped.
  jump_state_e           state;
  logic [Y_W-1:0]        y;
  logic signed [V_W-1:0] v;
  logic [X_W-1:0]        dx;
  logic                  done;

  logic [Y_W-1:0]        y_next;
  logic signed [V_W-1:0] v_next;
  logic                  land;
  logic [X_W:0]          dx_sum;
  logic [X_W-1:0]        dx_next;

  man_jump_integrator #(
    .Y_W     (Y_W),
    .V_W     (V_W),
    .GRAVITY (GRAVITY)
  ) u_integrator (
    .y      (y),
    .v      (v),
    .y_next (y_next),
    .v_next (v_next),
    .land   (land)
  );

  // Distance saturates rather than wrapping on very long jumps.
  assign dx_sum  = {1'b0, dx} + (X_W + 1)'(HSPEED);
  assign dx_next = dx_sum[X_W] ? '1 : dx_sum[X_W-1:0];

  always_ff @(posedge clk_machine or negedge rst_machine) begin
    if (!rst_machine) begin
      state <= ST_IDLE;
      y     <= '0;
      v     <= '0;
      dx    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_jump_start) begin
            v     <= V_W'(i_jump_v_init);
            y     <= '0;
            dx    <= '0;
            state <= ST_AIR;
          end
        end
        ST_AIR: begin
          if (i_tick) begin
            dx <= dx_next;
            if (land) begin
              y     <= '0;
              done  <= 1'b1;
              state <= ST_LAND;
            end else begin
              y <= y_next;
              v <= v_next;
            end
          end
        end
        ST_LAND: begin
          v     <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_man_y     = y;
  assign o_man_dx    = dx;
  assign o_vel       = v;
  assign o_jump_done = done;
  assign o_busy      = (state != ST_IDLE);
  assign o_falling   = (state == ST_AIR) && (v[V_W-1] || (v == '0));

endmodule

// File: tb/tb_man_jump_physics.sv
// Bench for man_jump_physics: default-physics instance plus a GRAVITY=1,
// X_W=8 instance for the max-velocity and distance-saturation cases.
`timescale 1ns/1ps
module tb_man_jump_physics;

  localparam int Y_W = 16;
  localparam int V_W = 10;
  localparam int X_W = 12;
  localparam int TW  = Y_W + V_W + X_W + 2;

  // ---------------- clock / reset ----------------
  logic clk_machine = 1'b0;
  logic rst_machine = 1'b0;
  always #20 clk_machine = ~clk_machine;

  // ---------------- DUT 0: default physics ----------------
  logic tick0 = 0, start0 = 0;
  logic [7:0] vin0 = 0;
  logic [Y_W-1:0] y0;
  logic [X_W-1:0] dx0;
  logic signed [V_W-1:0] vel0;
  logic busy0, fall0, done0;

  man_jump_physics u_dut0 (
    .clk_machine   (clk_machine),
    .rst_machine   (rst_machine),
    .i_tick        (tick0),
    .i_jump_start  (start0),
    .i_jump_v_init (vin0),
    .o_man_y       (y0),
    .o_man_dx      (dx0),
    .o_vel         (vel0),
    .o_busy        (busy0),
    .o_falling     (fall0),
    .o_jump_done   (done0)
  );

  // ---------------- DUT 1: GRAVITY=1, narrow dx ----------------
  logic tick1 = 0, start1 = 0;
  logic [7:0] vin1 = 0;
  logic [Y_W-1:0] y1;
  logic [7:0] dx1;
  logic signed [V_W-1:0] vel1;
  logic busy1, fall1, done1;

  man_jump_physics #(.X_W(8), .GRAVITY(1), .HSPEED(2)) u_dut1 (
    .clk_machine   (clk_machine),
    .rst_machine   (rst_machine),
    .i_tick        (tick1),
    .i_jump_start  (start1),
    .i_jump_v_init (vin1),
    .o_man_y       (y1),
    .o_man_dx      (dx1),
    .o_vel         (vel1),
    .o_busy        (busy1),
    .o_falling     (fall1),
    .o_jump_done   (done1)
  );

  // ---------------- scoreboard ----------------
  logic [TW-1:0] exp_q0[$];
  logic [TW-1:0] exp_q1[$];
  logic [X_W-1:0] done_q0[$];
  logic [X_W-1:0] done_q1[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_done0  = 0;
  int n_done1  = 0;
  int peak1    = 0;

  function automatic string fmt(input logic [TW-1:0] e);
    return $sformatf("y=%0d v=%0d dx=%0d fall=%0b done=%0b", e[TW-1 -: Y_W],
                     $signed(e[V_W+X_W+1 -: V_W]), e[X_W+1:2], e[1], e[0]);
  endfunction

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_traj(input int d, input int y, input int v, input int dx,
                           input bit f, input bit l);
    logic [TW-1:0] e;
    e = {Y_W'(y), V_W'(v), X_W'(dx), f, l};
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic push_done(input int d, input int dx);
    if (d == 0) done_q0.push_back(X_W'(dx));
    else        done_q1.push_back(X_W'(dx));
  endtask

  task automatic check_traj(input int d, input logic [TW-1:0] act);
    logic [TW-1:0] e;
    bit empty;
    n_checks++;
    empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
    if (empty) begin
      n_fail++;
      $display("FAIL traj%0d_unexpected: got %s, expected no update", d, fmt(act));
    end else begin
      if (d == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL traj%0d: got %s, expected %s", d, fmt(act), fmt(e));
      end
    end
  endtask

  task automatic check_done(input int d, input logic [X_W-1:0] act_dx);
    bit empty;
    empty = (d == 0) ? (done_q0.size() == 0) : (done_q1.size() == 0);
    if (empty) begin
      n_checks++;
      n_fail++;
      $display("FAIL done%0d_unexpected: got pulse with dx=%0d, expected none", d, act_dx);
    end else if (d == 0) begin
      check_eq("done0_dx", act_dx, done_q0.pop_front());
    end else begin
      check_eq("done1_dx", act_dx, done_q1.pop_front());
    end
  endtask

  // Monitor: a tick seen while airborne means updated outputs one edge later.
  logic pend0 = 0, pend1 = 0;
  always @(negedge clk_machine) begin
    if (pend0) check_traj(0, {y0, vel0, dx0, fall0, done0});
    if (pend1) check_traj(1, {y1, vel1, 4'b0, dx1, fall1, done1});
    if (done0) begin n_done0++; check_done(0, dx0); end
    if (done1) begin n_done1++; check_done(1, {4'b0, dx1}); end
    if (busy1 && int'(y1) > peak1) peak1 = int'(y1);
    pend0 = rst_machine && tick0 && busy0 && !done0;
    pend1 = rst_machine && tick1 && busy1 && !done1;
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk_machine);
    #5;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic strobe(input int d, input logic tk, input logic st, input logic [7:0] vi);
    if (d == 0) begin tick0 = tk; start0 = st; vin0 = vi; end
    else        begin tick1 = tk; start1 = st; vin1 = vi; end
    cycle();
    if (d == 0) begin tick0 = 0; start0 = 0; vin0 = 0; end
    else        begin tick1 = 0; start1 = 0; vin1 = 0; end
  endtask

  // Hand-computed trajectory for v_init=8, GRAVITY=4, HSPEED=2.
  task automatic push_nominal();
    push_traj(0, 8,  4,  2,  0, 0);
    push_traj(0, 12, 0,  4,  1, 0);
    push_traj(0, 12, -4, 6,  1, 0);
    push_traj(0, 8,  -8, 8,  1, 0);
    push_traj(0, 0,  -8, 10, 0, 1);
    push_done(0, 10);
  endtask

  task automatic run_nominal();
    strobe(0, 0, 1, 8);
    repeat (5) begin
      strobe(0, 1, 0, 0);
      idle(1);
    end
    idle(2);
  endtask

  // Reference step model used for the long GRAVITY=1 jump.
  task automatic push_model(input int d, input int vinit, input int g, input int h,
                            input int xmax, output int nticks);
    int y, v, dx, s;
    y = 0; v = vinit; dx = 0; nticks = 0;
    forever begin
      s = y + v;
      nticks++;
      dx = (dx + h > xmax) ? xmax : dx + h;
      if (s <= 0 && v <= 0) begin
        push_traj(d, 0, v, dx, 0, 1);
        push_done(d, dx);
        break;
      end
      y = s;
      v = v - g;
      push_traj(d, y, v, dx, (v <= 0), 0);
    end
  endtask

  task automatic end_phase(input string name, input int d0_before, input int exp_d0);
    check_eq({name, "_traj_left"}, exp_q0.size(), 0);
    check_eq({name, "_done_count"}, n_done0 - d0_before, exp_d0);
    check_eq({name, "_idle_busy"}, busy0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int mark;
    int nt;

    // Reset with random inputs
    rst_machine = 0;
    repeat (4) begin
      tick0  = 1'($urandom_range(0, 1));
      start0 = 1'($urandom_range(0, 1));
      vin0   = 8'($urandom_range(0, 255));
      tick1  = 1'($urandom_range(0, 1));
      start1 = 1'($urandom_range(0, 1));
      vin1   = 8'($urandom_range(0, 255));
      cycle();
      check_eq("rst_outputs0", {y0, dx0, vel0, busy0, fall0, done0}, 0);
      check_eq("rst_outputs1", {y1, dx1, vel1, busy1, fall1, done1}, 0);
    end
    tick0 = 0; start0 = 0; vin0 = 0;
    tick1 = 0; start1 = 0; vin1 = 0;
    rst_machine = 1;
    cycle();
    check_eq("post_rst_busy", busy0, 0);
    check_eq("post_rst_y", y0, 0);

    // Nominal jump
    mark = n_done0;
    push_nominal();
    run_nominal();
    end_phase("nominal", mark, 1);
    check_eq("nominal_dx_hold", dx0, 10);
    check_eq("nominal_vel_cleared", vel0, 0);

    // Zero launch velocity
    mark = n_done0;
    push_traj(0, 0, 0, 2, 0, 1);
    push_done(0, 2);
    strobe(0, 0, 1, 0);
    check_eq("zero_busy_air", busy0, 1);
    check_eq("zero_falling_air", fall0, 1);
    strobe(0, 1, 0, 0);
    idle(3);
    end_phase("zero", mark, 1);
    check_eq("zero_dx_hold", dx0, 2);

    // Restart attempts while airborne and during LAND are dropped
    mark = n_done0;
    push_nominal();
    strobe(0, 0, 1, 8);
    strobe(0, 1, 0, 0);
    strobe(0, 0, 1, 200);
    strobe(0, 1, 0, 0);
    strobe(0, 1, 1, 200);
    idle(1);
    strobe(0, 1, 0, 0);
    strobe(0, 1, 0, 0);
    strobe(0, 0, 1, 200);
    idle(2);
    end_phase("restart", mark, 1);

    // Tick coincident with start is ignored; gaps between ticks hold state
    mark = n_done0;
    push_nominal();
    strobe(0, 1, 1, 8);
    idle(3);
    check_eq("gated_y_before_tick", y0, 0);
    strobe(0, 1, 0, 0);
    idle(2);
    check_eq("gated_hold_y", y0, 8);
    strobe(0, 1, 0, 0);
    idle(4);
    strobe(0, 1, 0, 0);
    strobe(0, 1, 0, 0);
    strobe(0, 1, 0, 0);
    idle(3);
    end_phase("gated", mark, 1);

    // Async reset mid-jump at y=12
    mark = n_done0;
    push_traj(0, 8,  4, 2, 0, 0);
    push_traj(0, 12, 0, 4, 1, 0);
    strobe(0, 0, 1, 8);
    strobe(0, 1, 0, 0);
    strobe(0, 1, 0, 0);
    idle(1);
    check_eq("midrst_y_before", y0, 12);
    rst_machine = 0;
    #1;
    check_eq("midrst_outputs", {y0, dx0, vel0, busy0, fall0, done0}, 0);
    idle(2);
    rst_machine = 1;
    cycle();
    check_eq("midrst_done_count", n_done0 - mark, 0);
    push_nominal();
    run_nominal();
    end_phase("after_rst", mark, 1);

    // Max velocity with GRAVITY=1; dx saturates at 255 on the 8-bit instance
    mark = n_done1;
    peak1 = 0;
    push_model(1, 255, 1, 2, 255, nt);
    check_eq("max_tick_count", nt, 511);
    strobe(1, 0, 1, 255);
    for (int i = 0; i < nt; i++) strobe(1, 1, 0, 0);
    idle(3);
    check_eq("max_traj_left", exp_q1.size(), 0);
    check_eq("max_peak", peak1, 32640);
    check_eq("max_done_count", n_done1 - mark, 1);
    check_eq("max_dx_sat", dx1, 255);
    check_eq("max_y_landed", y1, 0);
    check_eq("max_busy", busy1, 0);

    check_eq("done_q0_left", done_q0.size(), 0);
    check_eq("done_q1_left", done_q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
